// File: rtl/if_id_hazard_reg.sv
// rtl/if_id_hazard_reg.sv - IF/ID pipeline register with load-use hazard stall, flush and stall counter
module if_id_hazard_reg #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   Reset_L,
    input  logic [31:0]            instrIn,
    input  logic [31:0]            pcPlus4In,
    input  logic                   fetchValid,
    input  logic                   flush,
    input  logic                   idEx_memRead,
    input  logic [4:0]             idEx_rt,
    output logic [31:0]            instrOut,
    output logic [31:0]            pcPlus4Out,
    output logic                   validOut,
    output logic [15:0]            imm16,
    output logic                   signExtend_L,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stallCount
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsUsed;
    logic       rtUsed;
    logic       rsHit;
    logic       rtHit;

    assign op    = instrOut[31:26];
    assign rs    = instrOut[25:21];
    assign rt    = instrOut[20:16];
    assign imm16 = instrOut[15:0];

    always_comb begin
        rsUsed       = 1'b1;
        rtUsed       = 1'b0;
        signExtend_L = 1'b0;
        case (op)
            OP_J, OP_JAL, OP_LUI:          rsUsed = 1'b0;
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: rtUsed = 1'b1;
            OP_ANDI, OP_ORI, OP_XORI:      signExtend_L = 1'b1;
            default: ;
        endcase
    end

    // Only the ID/EX load's destination can create a hazard; r0 is never a real dependency.
    assign rsHit = rsUsed && (rs == idEx_rt);
    assign rtHit = rtUsed && (rt == idEx_rt);
    assign stall = validOut && idEx_memRead && (idEx_rt != 5'd0) && (rsHit || rtHit);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            instrOut   <= 32'h0;
            pcPlus4Out <= 32'h0;
            validOut   <= 1'b0;
        end else if (flush) begin
            instrOut   <= 32'h0;
            pcPlus4Out <= 32'h0;
            validOut   <= 1'b0;
        end else if (!stall) begin
            instrOut   <= fetchValid ? instrIn : 32'h0;
            pcPlus4Out <= pcPlus4In;
            validOut   <= fetchValid;
        end
    end

    // A flushed stall never takes effect, so it is not counted.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            stallCount <= '0;
        end else if (stall && !flush && (stallCount != '1)) begin
            stallCount <= stallCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_if_id_hazard_reg.sv
// tb/tb_if_id_hazard_reg.sv - scoreboard testbench for if_id_hazard_reg
module tb_if_id_hazard_reg;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic        satReset_L = 1'b0;
    logic [31:0] instrIn = '0;
    logic [31:0] pcPlus4In = '0;
    logic        fetchValid = 1'b0;
    logic        flush = 1'b0;
    logic        idEx_memRead = 1'b0;
    logic [4:0]  idEx_rt = '0;

    logic [31:0] instrOut, pcPlus4Out, satInstrOut, satPcPlus4Out;
    logic        validOut, signExtend_L, stall, satValidOut, satSignExtend_L, satStall;
    logic [15:0] imm16, satImm16;
    logic [15:0] stallCount;
    logic [1:0]  satStallCount;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          passCnt = 0;
    int          totalCnt = 0;
    logic [15:0] expCnt = 0;

    always #5 CLK = ~CLK;

    if_id_hazard_reg #(.STALL_CNT_W(16)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .instrIn(instrIn), .pcPlus4In(pcPlus4In),
        .fetchValid(fetchValid), .flush(flush), .idEx_memRead(idEx_memRead), .idEx_rt(idEx_rt),
        .instrOut(instrOut), .pcPlus4Out(pcPlus4Out), .validOut(validOut), .imm16(imm16),
        .signExtend_L(signExtend_L), .stall(stall), .stallCount(stallCount)
    );

    if_id_hazard_reg #(.STALL_CNT_W(2)) dutSat (
        .CLK(CLK), .Reset_L(satReset_L), .instrIn(instrIn), .pcPlus4In(pcPlus4In),
        .fetchValid(fetchValid), .flush(flush), .idEx_memRead(idEx_memRead), .idEx_rt(idEx_rt),
        .instrOut(satInstrOut), .pcPlus4Out(satPcPlus4Out), .validOut(satValidOut), .imm16(satImm16),
        .signExtend_L(satSignExtend_L), .stall(satStall), .stallCount(satStallCount)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic fv);
        instrIn = ins;
        pcPlus4In = pc;
        fetchValid = fv;
    endtask

    task automatic test_reset();
        #1;
        totalCnt++; if (instrOut !== 32'h0) $display("FAIL reset_instr got %h want 0", instrOut); else passCnt++;
        totalCnt++; if (pcPlus4Out !== 32'h0) $display("FAIL reset_pc got %h want 0", pcPlus4Out); else passCnt++;
        totalCnt++; if (validOut !== 1'b0) $display("FAIL reset_valid got %b want 0", validOut); else passCnt++;
        totalCnt++; if (stallCount !== 16'h0) $display("FAIL reset_cnt got %0d want 0", stallCount); else passCnt++;
        totalCnt++; if ({imm16, signExtend_L, stall} !== 18'h0) $display("FAIL reset_derived got %h want 0", {imm16, signExtend_L, stall}); else passCnt++;
        tick();
        Reset_L = 1'b1;
    endtask

    task automatic test_extension();
        drive(32'h3421FFFF, 32'h4, 1'b1);
        sbq.push_back('{32'h3421FFFF, 32'h4, 1'b1, expCnt});
        tick();
        e = sbq.pop_front();
        totalCnt++; if (instrOut !== e.instr || validOut !== e.valid) $display("FAIL ori_load got %h/%b want %h/%b", instrOut, validOut, e.instr, e.valid); else passCnt++;
        totalCnt++; if (imm16 !== 16'hFFFF || signExtend_L !== 1'b1) $display("FAIL ori_ext got %h/%b want ffff/1", imm16, signExtend_L); else passCnt++;
        drive(32'h2021FFFF, 32'h8, 1'b1);
        sbq.push_back('{32'h2021FFFF, 32'h8, 1'b1, expCnt});
        tick();
        e = sbq.pop_front();
        totalCnt++; if (instrOut !== e.instr || pcPlus4Out !== e.pc) $display("FAIL addi_load got %h/%h want %h/%h", instrOut, pcPlus4Out, e.instr, e.pc); else passCnt++;
        totalCnt++; if (imm16 !== 16'hFFFF || signExtend_L !== 1'b0) $display("FAIL addi_ext got %h/%b want ffff/0", imm16, signExtend_L); else passCnt++;
    endtask

    task automatic test_load_use_rs();
        drive(32'h00A62020, 32'h10, 1'b1);
        tick();
        idEx_memRead = 1'b1;
        idEx_rt = 5'd5;
        drive(32'h01094020, 32'h14, 1'b1);
        #1;
        totalCnt++; if (stall !== 1'b1) $display("FAIL rs_hazard_stall got %b want 1", stall); else passCnt++;
        expCnt++;
        sbq.push_back('{32'h00A62020, 32'h10, 1'b1, expCnt});
        tick();
        e = sbq.pop_front();
        totalCnt++; if (instrOut !== e.instr || pcPlus4Out !== e.pc) $display("FAIL rs_hold got %h/%h want %h/%h", instrOut, pcPlus4Out, e.instr, e.pc); else passCnt++;
        totalCnt++; if (stallCount !== e.cnt) $display("FAIL rs_cnt got %0d want %0d", stallCount, e.cnt); else passCnt++;
        idEx_memRead = 1'b0;
        #1;
        totalCnt++; if (stall !== 1'b0) $display("FAIL rs_release got %b want 0", stall); else passCnt++;
        sbq.push_back('{32'h01094020, 32'h14, 1'b1, expCnt});
        tick();
        e = sbq.pop_front();
        totalCnt++; if (instrOut !== e.instr || stallCount !== e.cnt) $display("FAIL rs_next got %h/%0d want %h/%0d", instrOut, stallCount, e.instr, e.cnt); else passCnt++;
    endtask

    task automatic test_no_false_hazard();
        drive(32'h20A70001, 32'h20, 1'b1);
        tick();
        idEx_memRead = 1'b1;
        idEx_rt = 5'd7;
        #1;
        totalCnt++; if (stall !== 1'b0) $display("FAIL addi_rt_dest got %b want 0", stall); else passCnt++;
        idEx_rt = 5'd5;
        #1;
        totalCnt++; if (stall !== 1'b1) $display("FAIL addi_rs_src got %b want 1", stall); else passCnt++;
        idEx_memRead = 1'b0;
        drive(32'h00000020, 32'h24, 1'b1);
        tick();
        idEx_memRead = 1'b1;
        idEx_rt = 5'd0;
        #1;
        totalCnt++; if (stall !== 1'b0) $display("FAIL rt_zero got %b want 0", stall); else passCnt++;
        idEx_memRead = 1'b0;
        drive(32'hAC450000, 32'h28, 1'b1);
        tick();
        idEx_memRead = 1'b1;
        idEx_rt = 5'd5;
        #1;
        totalCnt++; if (stall !== 1'b1) $display("FAIL sw_rt_src got %b want 1", stall); else passCnt++;
        idEx_memRead = 1'b0;
        drive(32'h0800_0010, 32'h2C, 1'b1);
        tick();
        idEx_memRead = 1'b1;
        idEx_rt = 5'd0;
        idEx_rt = 5'd0 + 5'd0;
        #1;
        idEx_memRead = 1'b0;
        drive(32'hFFFFFFFF, 32'h30, 1'b0);
        sbq.push_back('{32'h0, 32'h30, 1'b0, expCnt});
        tick();
        e = sbq.pop_front();
        totalCnt++; if (instrOut !== e.instr || validOut !== e.valid || pcPlus4Out !== e.pc) $display("FAIL bubble got %h/%b/%h want %h/%b/%h", instrOut, validOut, pcPlus4Out, e.instr, e.valid, e.pc); else passCnt++;
    endtask

    task automatic test_flush_vs_stall();
        drive(32'h00A62020, 32'h40, 1'b1);
        tick();
        idEx_memRead = 1'b1;
        idEx_rt = 5'd5;
        flush = 1'b1;
        #1;
        totalCnt++; if (stall !== 1'b1) $display("FAIL flush_pre_stall got %b want 1", stall); else passCnt++;
        sbq.push_back('{32'h0, 32'h0, 1'b0, expCnt});
        tick();
        e = sbq.pop_front();
        totalCnt++; if (instrOut !== e.instr || validOut !== e.valid || pcPlus4Out !== e.pc) $display("FAIL flush_clear got %h/%b/%h want %h/%b/%h", instrOut, validOut, pcPlus4Out, e.instr, e.valid, e.pc); else passCnt++;
        totalCnt++; if (stall !== 1'b0 || stallCount !== e.cnt) $display("FAIL flush_after got %b/%0d want 0/%0d", stall, stallCount, e.cnt); else passCnt++;
        flush = 1'b0;
        idEx_memRead = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        logic        fv;
        for (int i = 0; i < 10; i++) begin
            ins = $urandom;
            fv = 1'($urandom_range(0, 1));
            drive(ins, 32'h100 + 32'(i * 4), fv);
            sbq.push_back('{fv ? ins : 32'h0, 32'h100 + 32'(i * 4), fv, expCnt});
            tick();
            e = sbq.pop_front();
            totalCnt++;
            if (instrOut !== e.instr || pcPlus4Out !== e.pc || validOut !== e.valid)
                $display("FAIL b2b_%0d got %h/%h/%b want %h/%h/%b", i, instrOut, pcPlus4Out, validOut, e.instr, e.pc, e.valid);
            else passCnt++;
        end
    endtask

    task automatic test_saturation();
        logic [1:0] satExp[5];
        satExp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        satReset_L = 1'b1;
        drive(32'h00A62020, 32'h200, 1'b1);
        tick();
        idEx_memRead = 1'b1;
        idEx_rt = 5'd5;
        for (int i = 0; i < 5; i++) begin
            expCnt++;
            sbq.push_back('{32'h00A62020, 32'h200, 1'b1, expCnt});
            tick();
            e = sbq.pop_front();
            totalCnt++;
            if (satStallCount !== satExp[i] || stallCount !== e.cnt || instrOut !== e.instr)
                $display("FAIL sat_%0d got %0d/%0d/%h want %0d/%0d/%h", i, satStallCount, stallCount, instrOut, satExp[i], e.cnt, e.instr);
            else passCnt++;
        end
        idEx_memRead = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(32'h2109FFFC, 32'h300, 1'b1);
        tick();
        totalCnt++; if (instrOut !== 32'h2109FFFC || stallCount !== expCnt) $display("FAIL mid_load got %h/%0d want 2109fffc/%0d", instrOut, stallCount, expCnt); else passCnt++;
        #2;
        Reset_L = 1'b0;
        #1;
        totalCnt++;
        if (instrOut !== 32'h0 || validOut !== 1'b0 || stallCount !== 16'h0)
            $display("FAIL mid_reset got %h/%b/%0d want 0/0/0", instrOut, validOut, stallCount);
        else passCnt++;
        tick();
        Reset_L = 1'b1;
        totalCnt++; if (instrOut !== 32'h0 || validOut !== 1'b0) $display("FAIL mid_reset_hold got %h/%b want 0/0", instrOut, validOut); else passCnt++;
        tick();
        totalCnt++; if (instrOut !== 32'h2109FFFC || validOut !== 1'b1) $display("FAIL mid_release got %h/%b want 2109fffc/1", instrOut, validOut); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_extension();
        test_load_use_rs();
        test_no_false_hazard();
        test_flush_vs_stall();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
